// File: rtl/ctr_e.sv
// ============================================================================
// Module   : ctr_e
// Purpose  : Execute-stage control slice: D/E instruction register plus E-stage
//            decode. Optional multiply/divide busy tracking under MULTDIV_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ctr_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_12,
  input  logic [5:0] func_12,
  input  logic [4:0] rt_12,
  input  logic [4:0] rd_12,
  input  logic       flush_E,
  output logic [5:0] op_23,
  output logic [5:0] func_23,
  output logic [2:0] ALUOp_E,
  output logic       ALUSrc_E,
  output logic       ExtOp_E,
  output logic [4:0] A3_E,
  output logic       RegWr_E,
  output logic [1:0] WDSel_E,
  output logic [1:0] Tnew_E,
  output logic       md_busy_E,
  output logic       md_stall
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_lui   = 6'b001111;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_jal   = 6'b000011;

  localparam logic [5:0] c_fn_addu  = 6'b100001;
  localparam logic [5:0] c_fn_subu  = 6'b100011;
  localparam logic [5:0] c_fn_jr    = 6'b001000;

  localparam logic [2:0] c_alu_add  = 3'b000;
  localparam logic [2:0] c_alu_sub  = 3'b001;
  localparam logic [2:0] c_alu_or   = 3'b010;
  localparam logic [2:0] c_alu_lui  = 3'b011;

  localparam logic [1:0] c_wd_alu   = 2'b00;
  localparam logic [1:0] c_wd_mem   = 2'b01;
  localparam logic [1:0] c_wd_pc8   = 2'b10;
  localparam logic [1:0] c_wd_md    = 2'b11;

  localparam logic [4:0] c_ra       = 5'd31;

  // --------------------------------------------------------------------------
  // D/E pipeline register
  // --------------------------------------------------------------------------
  logic [5:0] op_q,   op_d;
  logic [5:0] func_q, func_d;
  logic [4:0] rt_q,   rt_d;
  logic [4:0] rd_q,   rd_d;

  always_comb begin
    op_d   = op_12;
    func_d = func_12;
    rt_d   = rt_12;
    rd_d   = rd_12;
    if (flush_E) begin
      op_d   = '0;
      func_d = '0;
      rt_d   = '0;
      rd_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      func_q <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      op_q   <= op_d;
      func_q <= func_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
    end
  end

  assign op_23   = op_q;
  assign func_23 = func_q;

  // --------------------------------------------------------------------------
  // Instruction recognition on the registered fields
  // --------------------------------------------------------------------------
  logic w_rtype;
  logic w_is_addu, w_is_subu, w_is_ori, w_is_lui, w_is_lw, w_is_sw;
  logic w_is_beq, w_is_j, w_is_jal, w_is_jr;
  logic w_is_mult, w_is_div, w_is_mfhi, w_is_mflo;

  assign w_rtype   = (op_q == c_op_rtype);
  assign w_is_addu = w_rtype && (func_q == c_fn_addu);
  assign w_is_subu = w_rtype && (func_q == c_fn_subu);
  assign w_is_jr   = w_rtype && (func_q == c_fn_jr);
  assign w_is_ori  = (op_q == c_op_ori);
  assign w_is_lui  = (op_q == c_op_lui);
  assign w_is_lw   = (op_q == c_op_lw);
  assign w_is_sw   = (op_q == c_op_sw);
  assign w_is_beq  = (op_q == c_op_beq);
  assign w_is_j    = (op_q == c_op_j);
  assign w_is_jal  = (op_q == c_op_jal);

`ifdef MULTDIV_EN
  localparam logic [5:0] c_fn_mult = 6'b011000;
  localparam logic [5:0] c_fn_div  = 6'b011010;
  localparam logic [5:0] c_fn_mfhi = 6'b010000;
  localparam logic [5:0] c_fn_mflo = 6'b010010;

  assign w_is_mult = w_rtype && (func_q == c_fn_mult);
  assign w_is_div  = w_rtype && (func_q == c_fn_div);
  assign w_is_mfhi = w_rtype && (func_q == c_fn_mfhi);
  assign w_is_mflo = w_rtype && (func_q == c_fn_mflo);
`else
  assign w_is_mult = 1'b0;
  assign w_is_div  = 1'b0;
  assign w_is_mfhi = 1'b0;
  assign w_is_mflo = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // E-stage control decode
  // --------------------------------------------------------------------------
  logic       w_wr_class;
  logic [4:0] w_a3;

  always_comb begin
    ALUOp_E    = c_alu_add;
    ALUSrc_E   = 1'b0;
    ExtOp_E    = 1'b0;
    w_a3       = 5'd0;
    w_wr_class = 1'b0;
    WDSel_E    = c_wd_alu;
    Tnew_E     = 2'd0;

    if (w_is_subu || w_is_beq) ALUOp_E = c_alu_sub;
    else if (w_is_ori)         ALUOp_E = c_alu_or;
    else if (w_is_lui)         ALUOp_E = c_alu_lui;

    ALUSrc_E = w_is_ori || w_is_lui || w_is_lw || w_is_sw;
    ExtOp_E  = w_is_lw || w_is_sw || w_is_beq;

    if (w_is_addu || w_is_subu || w_is_mfhi || w_is_mflo) begin
      w_a3       = rd_q;
      w_wr_class = 1'b1;
    end else if (w_is_ori || w_is_lui || w_is_lw) begin
      w_a3       = rt_q;
      w_wr_class = 1'b1;
    end else if (w_is_jal) begin
      w_a3       = c_ra;
      w_wr_class = 1'b1;
    end

    if (w_is_lw)                     WDSel_E = c_wd_mem;
    else if (w_is_jal)               WDSel_E = c_wd_pc8;
    else if (w_is_mfhi || w_is_mflo) WDSel_E = c_wd_md;

    if (w_is_lw)
      Tnew_E = 2'd2;
    else if (w_is_addu || w_is_subu || w_is_ori || w_is_lui || w_is_mfhi || w_is_mflo)
      Tnew_E = 2'd1;
  end

  // Writes targeting $0 are architecturally dropped, so never advertise them.
  assign A3_E    = w_a3;
  assign RegWr_E = w_wr_class && (w_a3 != 5'd0);

  // j and jr carry no E-stage controls beyond the nop defaults.
  logic w_unused_jumps;
  assign w_unused_jumps = w_is_j | w_is_jr;

  // --------------------------------------------------------------------------
  // Multiply/divide busy tracking
  // --------------------------------------------------------------------------
`ifdef MULTDIV_EN
  logic [3:0] cnt_q, cnt_d;
  logic       w_start;
  logic       w_d_is_md;

  assign w_start = w_is_mult || w_is_div;

  always_comb begin
    cnt_d = cnt_q;
    if (w_start)
      cnt_d = w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    else if (cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  // The counter deliberately ignores flush_E: a bubble in E must not cancel
  // an operation already in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign w_d_is_md = (op_12 == c_op_rtype) &&
                     ((func_12 == c_fn_mult) || (func_12 == c_fn_div) ||
                      (func_12 == c_fn_mfhi) || (func_12 == c_fn_mflo));

  assign md_busy_E = (cnt_q != 4'd0);
  assign md_stall  = w_d_is_md && (w_start || md_busy_E);
`else
  logic [3:0] w_unused_cfg;
  assign w_unused_cfg = 4'(MULT_CYCLES) ^ 4'(DIV_CYCLES);

  assign md_busy_E = 1'b0;
  assign md_stall  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctr_e.sv
// ============================================================================
// Module   : tb_ctr_e
// Purpose  : Randomised self-checking bench for ctr_e against an
//            instruction-level reference model, plus directed literal checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ctr_e;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
`ifdef MULTDIV_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_12, func_12;
  logic [4:0] rt_12, rd_12;
  logic       flush_E;
  logic [5:0] op_23, func_23;
  logic [2:0] ALUOp_E;
  logic       ALUSrc_E, ExtOp_E, RegWr_E, md_busy_E, md_stall;
  logic [4:0] A3_E;
  logic [1:0] WDSel_E, Tnew_E;

  int n_vec = 0;
  int n_err = 0;

  ctr_e #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .op_12(op_12), .func_12(func_12), .rt_12(rt_12), .rd_12(rd_12),
    .flush_E(flush_E),
    .op_23(op_23), .func_23(func_23),
    .ALUOp_E(ALUOp_E), .ALUSrc_E(ALUSrc_E), .ExtOp_E(ExtOp_E),
    .A3_E(A3_E), .RegWr_E(RegWr_E), .WDSel_E(WDSel_E), .Tnew_E(Tnew_E),
    .md_busy_E(md_busy_E), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  // Instruction kinds of the reference model
  typedef enum int {K_NOP, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                    K_J, K_JAL, K_JR, K_MULT, K_DIV, K_MFHI, K_MFLO} kind_t;

  function automatic kind_t kind_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) begin
      if (fn == 6'b100001) return K_ADDU;
      if (fn == 6'b100011) return K_SUBU;
      if (fn == 6'b001000) return K_JR;
      if (MD_ON && fn == 6'b011000) return K_MULT;
      if (MD_ON && fn == 6'b011010) return K_DIV;
      if (MD_ON && fn == 6'b010000) return K_MFHI;
      if (MD_ON && fn == 6'b010010) return K_MFLO;
      return K_NOP;
    end
    case (op)
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_NOP;
    endcase
  endfunction

  // Reference state: what sits in E, and the remaining md busy cycles
  logic [5:0] m_op, m_fn;
  logic [4:0] m_rt, m_rd;
  int         m_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_op = 0; m_fn = 0; m_rt = 0; m_rd = 0; m_busy = 0;
    end else begin
      kind_t k;
      k = kind_of(m_op, m_fn);
      if (k == K_MULT)      m_busy = MULT_CYCLES;
      else if (k == K_DIV)  m_busy = DIV_CYCLES;
      else if (m_busy > 0)  m_busy = m_busy - 1;
      if (flush_E) begin
        m_op = 0; m_fn = 0; m_rt = 0; m_rd = 0;
      end else begin
        m_op = op_12; m_fn = func_12; m_rt = rt_12; m_rd = rd_12;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare every output against the model on every falling edge
  always @(negedge clk) begin
    if (!reset) begin
      kind_t k, kd;
      int a3, wr, alu, src, ext, wd, tn, dmd, stall;
      k  = kind_of(m_op, m_fn);
      kd = kind_of(op_12, func_12);
      alu = (k == K_SUBU || k == K_BEQ) ? 1 : (k == K_ORI) ? 2 : (k == K_LUI) ? 3 : 0;
      src = (k inside {K_ORI, K_LUI, K_LW, K_SW}) ? 1 : 0;
      ext = (k inside {K_LW, K_SW, K_BEQ}) ? 1 : 0;
      a3  = (k inside {K_ADDU, K_SUBU, K_MFHI, K_MFLO}) ? int'(m_rd) :
            (k inside {K_ORI, K_LUI, K_LW}) ? int'(m_rt) : (k == K_JAL) ? 31 : 0;
      wr  = (a3 != 0) ? 1 : 0;
      wd  = (k == K_LW) ? 1 : (k == K_JAL) ? 2 : (k inside {K_MFHI, K_MFLO}) ? 3 : 0;
      tn  = (k == K_LW) ? 2 : (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_MFHI, K_MFLO}) ? 1 : 0;
      dmd = (kd inside {K_MULT, K_DIV, K_MFHI, K_MFLO}) ? 1 : 0;
      stall = (dmd == 1 && (k inside {K_MULT, K_DIV} || m_busy != 0)) ? 1 : 0;
      chk("op_23",     op_23,     m_op);
      chk("func_23",   func_23,   m_fn);
      chk("ALUOp_E",   ALUOp_E,   alu);
      chk("ALUSrc_E",  ALUSrc_E,  src);
      chk("ExtOp_E",   ExtOp_E,   ext);
      chk("A3_E",      A3_E,      a3);
      chk("RegWr_E",   RegWr_E,   wr);
      chk("WDSel_E",   WDSel_E,   wd);
      chk("Tnew_E",    Tnew_E,    tn);
      chk("md_busy_E", md_busy_E, (m_busy != 0) ? 1 : 0);
      chk("md_stall",  md_stall,  stall);
    end
  end

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rt, input logic [4:0] rd, input logic f);
    op_12 = op; func_12 = fn; rt_12 = rt; rd_12 = rd; flush_E = f;
  endtask

  // Random instruction pool; the last entry is filled with arbitrary bits
  logic [11:0] pool [16];

  initial begin
    pool[0]  = {6'b000000, 6'b100001}; pool[1]  = {6'b000000, 6'b100011};
    pool[2]  = {6'b001101, 6'b000000}; pool[3]  = {6'b001111, 6'b101010};
    pool[4]  = {6'b100011, 6'b000000}; pool[5]  = {6'b101011, 6'b000000};
    pool[6]  = {6'b000100, 6'b000000}; pool[7]  = {6'b000010, 6'b000000};
    pool[8]  = {6'b000011, 6'b000000}; pool[9]  = {6'b000000, 6'b001000};
    pool[10] = {6'b000000, 6'b011000}; pool[11] = {6'b000000, 6'b011010};
    pool[12] = {6'b000000, 6'b010000}; pool[13] = {6'b000000, 6'b010010};
    pool[14] = {6'b000000, 6'b000000}; pool[15] = 12'h000;

    reset = 1'b1;
    drive(6'd0, 6'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst A3_E",    A3_E,    0);
    chk("rst RegWr_E", RegWr_E, 0);
    chk("rst Tnew_E",  Tnew_E,  0);
    chk("rst md_busy", md_busy_E, 0);

    // addu $8
    drive(6'b000000, 6'b100001, 5'd3, 5'd8, 1'b0);
    @(negedge clk); #1;
    chk("addu A3_E", A3_E, 8);
    chk("addu RegWr_E", RegWr_E, 1);
    chk("addu ALUOp_E", ALUOp_E, 0);
    chk("addu ALUSrc_E", ALUSrc_E, 0);
    chk("addu WDSel_E", WDSel_E, 0);
    chk("addu Tnew_E", Tnew_E, 1);

    // lw $9 followed by a flushed edge
    drive(6'b100011, 6'b000000, 5'd9, 5'd4, 1'b0);
    @(negedge clk); #1;
    chk("lw A3_E", A3_E, 9);
    chk("lw WDSel_E", WDSel_E, 1);
    chk("lw Tnew_E", Tnew_E, 2);
    chk("lw ExtOp_E", ExtOp_E, 1);
    flush_E = 1'b1;
    @(negedge clk); #1;
    chk("bubble op_23", op_23, 0);
    chk("bubble A3_E", A3_E, 0);
    chk("bubble Tnew_E", Tnew_E, 0);
    chk("bubble WDSel_E", WDSel_E, 0);

    // Asynchronous reset with lw in E, released before the next rising edge
    flush_E = 1'b0;
    @(negedge clk); #1;
    chk("lw2 Tnew_E", Tnew_E, 2);
    #1 reset = 1'b1;
    #1;
    chk("async A3_E", A3_E, 0);
    chk("async Tnew_E", Tnew_E, 0);
    chk("async WDSel_E", WDSel_E, 0);
    chk("async op_23", op_23, 0);
    #1 reset = 1'b0;

    // jal
    drive(6'b000011, 6'b000000, 5'd0, 5'd0, 1'b0);
    @(negedge clk); #1;
    chk("jal A3_E", A3_E, 31);
    chk("jal RegWr_E", RegWr_E, 1);
    chk("jal WDSel_E", WDSel_E, 2);
    chk("jal Tnew_E", Tnew_E, 0);

    // ori to $0
    drive(6'b001101, 6'b000000, 5'd0, 5'd7, 1'b0);
    @(negedge clk); #1;
    chk("ori ALUOp_E", ALUOp_E, 2);
    chk("ori ALUSrc_E", ALUSrc_E, 1);
    chk("ori ExtOp_E", ExtOp_E, 0);
    chk("ori A3_E", A3_E, 0);
    chk("ori RegWr_E", RegWr_E, 0);

`ifdef MULTDIV_EN
    // mult in E, mflo waiting in D
    drive(6'b000000, 6'b011000, 5'd1, 5'd2, 1'b0);
    @(negedge clk);
    drive(6'b000000, 6'b010010, 5'd0, 5'd5, 1'b0);
    #1 chk("mult start md_stall", md_stall, 1);
    flush_E = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 chk("mult md_busy_E", md_busy_E, 1);
      chk("mult md_stall", md_stall, 1);
      @(negedge clk);
    end
    #1 chk("mult done md_busy_E", md_busy_E, 0);
    chk("mult done md_stall", md_stall, 0);

    drive(6'b000000, 6'b011010, 5'd1, 5'd2, 1'b0);
    @(negedge clk);
    drive(6'b000000, 6'b010010, 5'd0, 5'd5, 1'b1);
    #1 chk("div start md_stall", md_stall, 1);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 chk("div md_busy_E", md_busy_E, 1);
      @(negedge clk);
    end
    #1 chk("div done md_busy_E", md_busy_E, 0);
`endif

    // Random traffic, checked cycle by cycle against the model
    for (int n = 0; n < 600; n++) begin
      logic [11:0] ins;
      logic [4:0]  rt, rd;
      ins = pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 15) == 0) ins = 12'($urandom);
      rt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      drive(ins[11:6], ins[5:0], rt, rd, ($urandom_range(0, 4) == 0));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ctr_e.md
Name: ctr_e

Overview:
- Execute-stage control slice of the 5-stage MIPS pipeline.
- Latches the instruction identity (op/func/register fields) from decode into the D/E pipeline register, and inserts a bubble on flush.
- Decodes ALU, extender, write-destination and write-data-select controls for the E stage.
- Publishes Tnew_E and the forwarded op_23/func_23/RegWr_E that feed the memory-stage controller.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult starts (MULTDIV_EN only).
- DIV_CYCLES, 10, busy cycles after a div starts (MULTDIV_EN only).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- op_12  input  6  opcode of instruction in D.
- func_12  input  6  function field of instruction in D.
- rt_12  input  5  rt field of instruction in D.
- rd_12  input  5  rd field of instruction in D.
- flush_E  input  1  load a bubble into E on this edge (driven by hazard stall/flush).
- op_23  output  6  registered opcode now in E.
- func_23  output  6  registered function field now in E.
- ALUOp_E  output  3  000 add, 001 sub, 010 or, 011 lui (imm<<16).
- ALUSrc_E  output  1  1 = immediate operand B.
- ExtOp_E  output  1  1 = sign-extend immediate, 0 = zero-extend.
- A3_E  output  5  destination register of instruction in E.
- RegWr_E  output  1  instruction in E writes the register file.
- WDSel_E  output  2  00 ALU, 01 memory, 10 PC+8.
- Tnew_E  output  2  cycles until the E instruction's result exists.
- md_busy_E  output  1  multiply/divide unit busy (MULTDIV_EN only).
- md_stall  output  1  stall request for an md-class instruction in D (MULTDIV_EN only).

Behaviour:
- D/E register:
  - Fields op_23, func_23, rt_23, rd_23 load from the _12 inputs on each rising clk.
  - If flush_E=1, all fields load 0 (nop).
  - Async reset forces all fields to 0 immediately.
- Decode is combinational from the registered fields only. Recognised: addu, subu, ori, lui, lw, sw, beq, j, jal, jr. Any other encoding, including all-zero, is a nop.
- ALUOp_E:
  - subu, beq → 001.
  - ori → 010.
  - lui → 011.
  - All others → 000.
- ALUSrc_E = 1 for ori, lui, lw, sw.
- ExtOp_E = 1 for lw, sw, beq; 0 otherwise.
- A3_E:
  - addu, subu → rd_23.
  - ori, lui, lw → rt_23.
  - jal → 31.
  - Otherwise → 0.
- RegWr_E = 1 for addu, subu, ori, lui, lw, jal, and only when A3_E != 0. Writes to $0 are suppressed.
- WDSel_E: lw → 01; jal → 10; else 00.
- Tnew_E: lw → 2; addu/subu/ori/lui → 1; jal and all others → 0.
  - The memory stage then sees lw at 1, everything else at 0.
- Reset values: every output is 0, which is the nop decode. A3_E=0, Tnew_E=0, md_busy_E=0, md_stall=0.
- No internal stall hold. A D-stage stall is expressed by asserting flush_E; E never re-holds its contents.
- Latency: control for the instruction in D appears on outputs one clk after the edge that captures it.

Optional Feature:
- Macro: MULTDIV_EN.
- Defined:
  - Adds decode of mult (func 011000), div (011010), mfhi (010000), mflo (010010), all with op 000000.
  - mfhi/mflo: A3_E=rd_23, RegWr_E=1 if rd_23≠0, WDSel_E=11, Tnew_E=1.
  - start = mult|div in E (combinational).
  - On the rising edge where start=1, a 4-bit down-counter loads MULT_CYCLES or DIV_CYCLES. Otherwise it decrements toward 0 and saturates at 0.
  - md_busy_E = (count != 0).
  - md_stall = (D op/func is mult, div, mfhi or mflo) & (start | md_busy_E).
  - flush_E does not disturb the counter. Async reset clears it.
  - A new start while busy reloads the counter; this cannot occur legally because of md_stall.
- Undefined: those encodings decode as nop. md_busy_E and md_stall are tied to 0. No counter exists.

Test Plan:
- Reset: assert reset mid-cycle with lw in E → all outputs drop to 0 asynchronously, without waiting for clk.
- addu, op_12=0, func_12=100001, rd_12=8, clock once → A3_E=8, RegWr_E=1, ALUOp_E=000, ALUSrc_E=0, WDSel_E=00, Tnew_E=1.
- lw rt_12=9 then flush_E=1 on the next edge → first cycle: A3_E=9, WDSel_E=01, Tnew_E=2, ExtOp_E=1. Next cycle: all zero (bubble).
- jal → A3_E=31, RegWr_E=1, WDSel_E=10, Tnew_E=0.
- ori with rt_12=0 → ALUOp_E=010, ALUSrc_E=1, ExtOp_E=0, A3_E=0, RegWr_E=0.
- MULTDIV_EN: mult in E with mflo in D → md_stall=1 in the start cycle. md_busy_E is high for exactly 5 following cycles. md_stall drops the cycle count reaches 0. A div gives 10 cycles.
